// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: programmable timer, synchronized external lines, priority request FSM
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   reset    - asynchronous, active-high reset
//   opcode   - current instruction word; timer instruction is opcode[15:10] = 6'b101000
//   ext_irq  - asynchronous external interrupt lines, rising-edge sensitive
//   iack     - one-cycle CPU accept pulse for the presented request
//   iret     - one-cycle end-of-service pulse
//   ie1..ie4 - one-hot request lines (ie1 timer, ie2..ie4 ext_irq[0..2])
//   ivec     - index of the source in service (0 timer, 1..3 ext_irq[0..2])
//   busy     - high while a request is being serviced
module intr_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] opcode,
    input  logic [2:0]  ext_irq,
    input  logic        iack,
    input  logic        iret,
    output logic        ie1,
    output logic        ie2,
    output logic        ie3,
    output logic        ie4,
    output logic [1:0]  ivec,
    output logic        busy
);

    // Fewer than two flops is not a synchronizer; clamp silently.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    // ---------------- timer ----------------
    logic       tmr_en;
    logic [2:0] tmr_base;
    logic [5:0] tmr_limit;
    logic [6:0] presc;
    logic [5:0] tick_cnt;
    logic       timer_op;
    logic       tmr_run;
    logic [6:0] presc_max;
    logic       tick;
    logic       timer_hit;

    assign timer_op  = (opcode[15:10] == 6'b101000);
    assign tmr_run   = tmr_en && (tmr_limit != 6'd0);
    // Prescaler terminal count is 2^B - 1, so a tick lands every 2^B clocks.
    assign presc_max = 7'((8'd1 << tmr_base) - 8'd1);
    assign tick      = tmr_run && (presc == presc_max);
    assign timer_hit = tick && ((tick_cnt + 6'd1) == tmr_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_en    <= 1'b0;
            tmr_base  <= 3'd0;
            tmr_limit <= 6'd0;
            presc     <= 7'd0;
            tick_cnt  <= 6'd0;
        end else if (timer_op) begin
            tmr_en    <= opcode[9];
            tmr_base  <= opcode[8:6];
            tmr_limit <= opcode[5:0];
            presc     <= 7'd0;
            tick_cnt  <= 6'd0;
        end else if (!tmr_run) begin
            presc     <= 7'd0;
            tick_cnt  <= 6'd0;
        end else if (tick) begin
            presc     <= 7'd0;
            tick_cnt  <= timer_hit ? 6'd0 : tick_cnt + 6'd1;
        end else begin
            presc     <= presc + 7'd1;
        end
    end

    // ---------------- external line synchronizers ----------------
    logic [2:0] sync_q [SS];
    logic [2:0] sync_prev;
    logic [2:0] ext_rise;

    assign ext_rise = sync_q[SS-1] & ~sync_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SS; i++) begin
                sync_q[i] <= 3'b000;
            end
            sync_prev <= 3'b000;
        end else begin
            sync_q[0] <= ext_irq;
            for (int i = 1; i < SS; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_prev <= sync_q[SS-1];
        end
    end

    // ---------------- pending bits ----------------
    // bit 0 timer, bits 1..3 ext_irq[0..2]; a new event beats a same-cycle clear.
    state_t     state;
    logic [1:0] cur_src;
    logic [3:0] pend;
    logic [3:0] pend_set;
    logic [3:0] pend_clr;
    logic [1:0] sel_idx;
    logic [3:0] ie_q;

    assign pend_set = {ext_rise, timer_hit};
    assign pend_clr = (state == S_REQ && iack) ? (4'b0001 << cur_src) : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 4'b0000;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    always_comb begin
        sel_idx = 2'd0;
        if (pend[0]) begin
            sel_idx = 2'd0;
        end else if (pend[1]) begin
            sel_idx = 2'd1;
        end else if (pend[2]) begin
            sel_idx = 2'd2;
        end else begin
            sel_idx = 2'd3;
        end
    end

    // ---------------- request FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cur_src <= 2'd0;
            ie_q    <= 4'b0000;
            ivec    <= 2'd0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend != 4'b0000) begin
                        cur_src <= sel_idx;
                        ie_q    <= 4'b0001 << sel_idx;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (iack) begin
                        ie_q  <= 4'b0000;
                        ivec  <= cur_src;
                        busy  <= 1'b1;
                        state <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (iret) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    ie_q  <= 4'b0000;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ie1 = ie_q[0];
    assign ie2 = ie_q[1];
    assign ie3 = ie_q[2];
    assign ie4 = ie_q[3];

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] opcode;
    logic [2:0]  ext_irq;
    logic        iack;
    logic        iret;
    logic        ie1, ie2, ie3, ie4;
    logic [1:0]  ivec;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wire [3:0] ie_all = {ie4, ie3, ie2, ie1};

    intr_ctrl #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .ext_irq (ext_irq),
        .iack    (iack),
        .iret    (iret),
        .ie1     (ie1),
        .ie2     (ie2),
        .ie3     (ie3),
        .ie4     (ie4),
        .ivec    (ivec),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for any request line; counts negedges waited.
    task automatic wait_ie(input string tag, input int bound, output int n);
        n = 0;
        while (ie_all == 4'b0000 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_seen"}, 32'(ie_all != 4'b0000), 32'd1);
    endtask

    task automatic ie_cycles(input int ncyc, output int hits);
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (ie_all != 4'b0000) hits++;
        end
    endtask

    task automatic pulse_iack;
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
    endtask

    task automatic pulse_iret;
        iret = 1'b1;
        @(negedge clk);
        iret = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        int hits;
        int t0;
        int t1;

        reset   = 1'b1;
        opcode  = 16'h0000;
        ext_irq = 3'b000;
        iack    = 1'b0;
        iret    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ie",   32'(ie_all), 32'd0);
        check_eq("rst_ivec", 32'(ivec),   32'd0);
        check_eq("rst_busy", 32'(busy),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // iack/iret while idle must be ignored
        pulse_iack;
        pulse_iret;
        repeat (3) @(negedge clk);
        check_eq("stray_ie",   32'(ie_all), 32'd0);
        check_eq("stray_busy", 32'(busy),   32'd0);

        // timer: enable 1, B = 2, U = 5 -> 20 clocks + 1 FSM clock
        opcode = 16'hA285;
        @(negedge clk);
        opcode = 16'h0000;
        t0 = cyc;
        wait_ie("tmr_first", 100, n);
        check_eq("tmr_first_lat", 32'(cyc - t0), 32'd21);
        check_eq("tmr_first_ie",  32'(ie_all),   32'b0001);
        t1 = cyc;
        pulse_iack;
        check_eq("tmr_ack_busy", 32'(busy),   32'd1);
        check_eq("tmr_ack_ivec", 32'(ivec),   32'd0);
        check_eq("tmr_ack_ie",   32'(ie_all), 32'd0);
        pulse_iret;
        check_eq("tmr_ret_busy", 32'(busy), 32'd0);
        wait_ie("tmr_second", 100, n);
        check_eq("tmr_period",    32'(cyc - t1), 32'd20);
        check_eq("tmr_second_ie", 32'(ie_all),   32'b0001);
        t1 = cyc;

        // stay in service past the next timer hit, then stop the timer
        pulse_iack;
        while (cyc < t1 + 24) @(negedge clk);
        check_eq("svc_no_nest", 32'(ie_all), 32'd0);
        opcode = 16'hA280;
        @(negedge clk);
        opcode = 16'h0000;
        pulse_iret;
        wait_ie("tmr_kept", 5, n);
        check_eq("tmr_pend_kept", 32'(ie_all), 32'b0001);
        pulse_iack;
        pulse_iret;
        ie_cycles(100, hits);
        check_eq("tmr_u0_stopped", 32'(hits), 32'd0);

        // restart then disable before the first hit
        opcode = 16'hA285;
        @(negedge clk);
        opcode = 16'h0000;
        repeat (10) @(negedge clk);
        opcode = 16'hA085;
        @(negedge clk);
        opcode = 16'h0000;
        ie_cycles(100, hits);
        check_eq("tmr_en0_stopped", 32'(hits), 32'd0);

        // ext_irq[0] and ext_irq[2] together: ext0 first, then ext2
        ext_irq = 3'b101;
        wait_ie("pri_a", 10, n);
        check_eq("pri_ie2", 32'(ie_all), 32'b0010);
        pulse_iack;
        check_eq("pri_ivec1", 32'(ivec), 32'd1);
        pulse_iret;
        wait_ie("pri_b", 10, n);
        check_eq("pri_ie4", 32'(ie_all), 32'b1000);
        pulse_iack;
        check_eq("pri_ivec3", 32'(ivec), 32'd3);
        check_eq("pri_busy",  32'(busy), 32'd1);
        pulse_iret;
        ext_irq = 3'b000;
        ie_cycles(10, hits);
        check_eq("pri_quiet", 32'(hits), 32'd0);

        // ext_irq[1] edge while busy waits for iret
        ext_irq = 3'b001;
        wait_ie("busy_a", 10, n);
        check_eq("busy_ie2", 32'(ie_all), 32'b0010);
        pulse_iack;
        ext_irq = 3'b011;
        ie_cycles(10, hits);
        check_eq("busy_no_req", 32'(hits), 32'd0);
        check_eq("busy_held",   32'(busy), 32'd1);
        pulse_iret;
        wait_ie("busy_b", 5, m);
        check_eq("busy_iret_lat", 32'((m + 1) <= 2), 32'd1);
        check_eq("busy_ie3",      32'(ie_all),       32'b0100);
        pulse_iack;
        check_eq("busy_ivec2", 32'(ivec), 32'd2);
        pulse_iret;
        ext_irq = 3'b000;
        ie_cycles(6, hits);
        check_eq("busy_quiet", 32'(hits), 32'd0);

        // ext_irq[0] detect lands on the iack edge: pending must survive
        ext_irq = 3'b001;
        wait_ie("sw_a", 10, n);
        check_eq("sw_ie2", 32'(ie_all), 32'b0010);
        ext_irq = 3'b000;
        repeat (4) @(negedge clk);
        ext_irq = 3'b001;
        @(negedge clk);
        @(negedge clk);
        pulse_iack;
        check_eq("sw_busy", 32'(busy), 32'd1);
        check_eq("sw_ivec", 32'(ivec), 32'd1);
        pulse_iret;
        wait_ie("sw_b", 5, n);
        check_eq("sw_ie2_again", 32'(ie_all), 32'b0010);
        pulse_iack;
        pulse_iret;
        ie_cycles(10, hits);
        check_eq("sw_quiet", 32'(hits), 32'd0);

        // reset during REQ with ie3 high
        ext_irq = 3'b010;
        wait_ie("rst_req", 10, n);
        check_eq("rst_req_ie3",  32'(ie_all), 32'b0100);
        check_eq("pre_rst_ivec", 32'(ivec),   32'd1);
        reset   = 1'b1;
        ext_irq = 3'b000;
        #1;
        check_eq("async_rst_ie",   32'(ie_all), 32'd0);
        check_eq("async_rst_busy", 32'(busy),   32'd0);
        check_eq("async_rst_ivec", 32'(ivec),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        ie_cycles(30, hits);
        check_eq("post_rst_quiet", 32'(hits), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each external-line synchronizer (minimum 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  16  current instruction word from program memory.
REQ-005 SHALL have port ext_irq  input  3  asynchronous external interrupt lines, rising-edge sensitive.
REQ-006 SHALL have port iack  input  1  one-cycle CPU accept pulse for the presented request.
REQ-007 SHALL have port iret  input  1  one-cycle end-of-service pulse from the CPU.
REQ-008 SHALL have ports ie1, ie2, ie3, ie4  output  1 each  one-hot request lines to the control unit: ie1 = timer, ie2..ie4 = ext_irq[0..2].
REQ-009 SHALL have port ivec  output  2  index of the source in service (0 timer, 1..3 ext_irq[0..2]).
REQ-010 SHALL have port busy  output  1  high while a request is being serviced.

Function
REQ-011 SHALL decode a timer instruction when opcode[15:10] = 6'b101000 and sample enable = opcode[9], base B = opcode[8:6] and threshold U = opcode[5:0] on that clock edge.
REQ-012 SHALL restart the timer on every decoded timer instruction: prescaler and 6-bit tick counter cleared, new B and U held until the next timer instruction.
REQ-013 SHALL generate one tick every 2^B clocks (B = 0: every clock) while enabled, using a 7-bit prescaler that wraps to 0 at a tick.
REQ-014 SHALL set timer pending when the tick counter reaches U, exactly U*2^B clocks after the configuring edge, then clear the counter and continue periodically.
REQ-015 SHALL treat U = 0 or enable = 0 as timer stopped: counters held at 0, no timer pending generated, any existing pending kept.
REQ-016 SHALL pass each ext_irq bit through a SYNC_STAGES-flop synchronizer and set its pending bit on a detected 0->1 transition of the synchronized value.
REQ-017 SHALL keep pending bits single (non-counting): an event on an already-pending source is absorbed.
REQ-018 SHALL implement FSM states IDLE, REQ and SERVICE; outputs are registered and depend on state only.
REQ-019 SHALL, in IDLE with any pending bit set, select the highest-priority source (timer > ext0 > ext1 > ext2), latch it and enter REQ on the next edge.
REQ-020 SHALL, in REQ, hold exactly one ie line high for the latched source until iack; a higher-priority event arriving during REQ does not change the request.
REQ-021 SHALL, on iack in REQ, clear the latched pending bit, load ivec, drop all ie lines, raise busy and enter SERVICE.
REQ-022 SHALL, in SERVICE, issue no new request (no nesting) and return to IDLE with busy low on iret.
REQ-023 SHALL ignore iack outside REQ and iret outside SERVICE.
REQ-024 SHALL keep the pending bit set when a new event for a source arrives in the same cycle its pending bit is cleared by iack (set wins).
REQ-025 SHALL continue capturing events into pending bits during REQ and SERVICE.

Reset
REQ-026 SHALL on reset assertion immediately force state IDLE, ie1..ie4 = 0, ivec = 0, busy = 0, clear all pending bits, synchronizers, prescaler and tick counter, and set timer enable = 0, B = 0, U = 0.
REQ-027 SHALL abandon any REQ or SERVICE in progress on reset and, after release, raise no request until a new event occurs.

Verification
REQ-028 SHALL pass: timer instruction 16'hA285 (enable 1, B = 2, U = 5) -> ie1 rises 20 clocks after the configuring edge plus one clock of FSM latency, and repeats every 20 clocks after iack/iret.
REQ-029 SHALL pass: ext_irq[2] and ext_irq[0] rising in the same cycle -> ie2 asserted first; after iack and iret, ie4 asserted with ivec = 3 on its accept.
REQ-030 SHALL pass: ext_irq[1] edge while busy = 1 -> no ie change until iret, then ie3 asserted within 2 clocks.
REQ-031 SHALL pass: iack with ext_irq[0] re-edging so its detect coincides with the iack edge -> pending stays 1, and ie2 reasserts after the following iret.
REQ-032 SHALL pass: reset asserted mid-REQ with ie3 high -> ie3, busy and ivec go 0 asynchronously; no request follows after release without new stimulus.
REQ-033 SHALL pass: timer instruction with U = 0, or with enable = 0, after a running configuration -> no further ie1 pulses; an already-pending timer request is still delivered.
